// File: rtl/hazard_pkg.sv
// Purpose : shared types and helpers for the ID/EX hazard scoreboard.
// Latency : n/a (types, constants and a pure compare function).
// Backpressure: n/a.
//
// RA_W is the register-address width carried in a tracking slot; the top's
// REG_W is zero-extended into it, so REG_W must not exceed RA_W.
package hazard_pkg;

   localparam int RA_W = 5;

   // One in-flight instruction as seen by the scoreboard.
   typedef struct packed {
      logic            v;   // slot holds a real instruction
      logic [RA_W-1:0] rd;  // destination register
      logic            rw;  // writes rd
      logic            mr;  // is a load (data only available after MEM)
   } slot_t;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_e;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   // True when slot s will write register r; x0 never matches.
   function automatic logic slot_writes(input slot_t s, input logic [RA_W-1:0] r);
      return s.v && s.rw && (s.rd != '0) && (s.rd == r);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Purpose : pick the EX operand source for one register read of the ID instruction.
// Latency : combinational; the caller registers the result as it enters EX.
// Backpressure: none; kill forces the regfile select while a bubble is inserted.
//
// Ports: src/src_use - source register and whether it is read;
//        kill        - ID instruction is not entering EX this edge;
//        ex_slot/mem_slot - producers now in EX and MEM (they become EX/MEM
//                      and MEM/WB on the edge the consumer enters EX);
//        sel         - FWD_RF / FWD_EXMEM / FWD_MEMWB.
module fwd_select
   import hazard_pkg::*;
(
   input  logic [RA_W-1:0] src,
   input  logic            src_use,
   input  logic            kill,
   input  slot_t           ex_slot,
   input  slot_t           mem_slot,
   output logic [1:0]      sel
);

   // Only the EX producer's load flag matters: a load in MEM has its data in
   // MEM/WB by the time the consumer executes.
   logic unused_mem_mr;
   assign unused_mem_mr = mem_slot.mr;

   always_comb begin
      sel = FWD_RF;
      if (src_use && !kill) begin
         // A load in EX cannot feed EX/MEM; the hazard logic stalls instead.
         if (slot_writes(ex_slot, src) && !ex_slot.mr) begin
            sel = FWD_EXMEM;
         end else if (slot_writes(mem_slot, src)) begin
            sel = FWD_MEMWB;
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose : load-use stall/bubble, branch squash and registered forwarding selects for ID/EX.
// Latency : stall/bubble combinational from ID; fwdA/fwdB registered with the ID/EX payload.
// Backpressure: stall holds PC and IF/ID; bubble zeroes ID/EX control; flush beats a hazard.
//
// Ports: clk, rst (async, active-low); id_* describe the decoding instruction;
//        flush_in squashes it; stall/bubble to the pipeline; fwdA/fwdB to EX
//        operand muxes; stall_cnt saturating count of stalled cycles.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_RegWrite,
   input  logic             id_MemRead,
   input  logic             flush_in,
   output logic             stall,
   output logic             bubble,
   output logic [1:0]       fwdA,
   output logic [1:0]       fwdB,
   output logic [CNT_W-1:0] stall_cnt
);

   slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   state_e           state_q, state_d;
   logic [1:0]       rem_q, rem_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RA_W-1:0]  rs1, rs2;
   logic             haz;

   // The WB slot is kept for pipeline visibility only: the regfile is
   // write-first, so nothing downstream of MEM ever needs forwarding.
   logic unused_wb;
   assign unused_wb = ^wb_q;

   assign rs1 = RA_W'(id_rs1);
   assign rs2 = RA_W'(id_rs2);

   always_comb begin
      haz = id_valid && ex_q.mr &&
            ((id_use_rs1 && slot_writes(ex_q, rs1)) ||
             (id_use_rs2 && slot_writes(ex_q, rs2)));
      stall  = !flush_in && ((state_q == STALL) || haz);
      bubble = flush_in || stall;
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (flush_in) begin
         state_d = RUN;
         rem_d   = '0;
      end else if (state_q == STALL) begin
         rem_d = rem_q - 2'd1;
         if (rem_q == 2'd1) begin
            state_d = RUN;
         end
      end else if (haz && (LOAD_LAT > 1)) begin
         // The RUN cycle that detects the hazard is the first stall cycle.
         state_d = STALL;
         rem_d   = 2'(LOAD_LAT - 1);
      end
   end

   always_comb begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '0;
      if (id_valid && !bubble) begin
         ex_d.v  = 1'b1;
         ex_d.rd = RA_W'(id_rd);
         ex_d.rw = id_RegWrite;
         ex_d.mr = id_MemRead;
      end
      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   fwd_select u_fwd_a (
      .src      (rs1),
      .src_use  (id_use_rs1),
      .kill     (bubble),
      .ex_slot  (ex_q),
      .mem_slot (mem_q),
      .sel      (fwd_a_d)
   );

   fwd_select u_fwd_b (
      .src      (rs2),
      .src_use  (id_use_rs2),
      .kill     (bubble),
      .ex_slot  (ex_q),
      .mem_slot (mem_q),
      .sel      (fwd_b_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         state_q <= RUN;
         rem_q   <= '0;
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
         cnt_q   <= '0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         state_q <= state_d;
         rem_q   <= rem_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fwdA      = fwd_a_q;
   assign fwdB      = fwd_b_q;
   assign stall_cnt = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Consumer-side companion to the ID/EX pipeline register. Tracks the destination registers of in-flight instructions in the EX, MEM and WB stages.
- Detects load-use hazards and holds PC and IF/ID while a bubble is inserted into ID/EX.
- Produces registered forwarding selects that enter EX together with the ID/EX payload.
- Also squashes the decoding instruction on a taken branch and keeps a stall performance counter.

Parameters:
REG_W, 5, register-address width
LOAD_LAT, 1, stall cycles per load-use hazard (1..3)
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_W  source 1 of ID instruction
id_rs2  in  REG_W  source 2 of ID instruction
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_W  destination of ID instruction
id_RegWrite  in  1  ID instruction writes rd
id_MemRead  in  1  ID instruction is a load
flush_in  in  1  taken branch resolved in EX; squash ID
stall  out  1  hold PC and IF/ID (combinational)
bubble  out  1  zero ID/EX control fields this edge (combinational)
fwdA  out  2  EX operand A select, registered: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwdB  out  2  EX operand B select, same encoding
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - All slots invalid; FSM in RUN; remaining counter 0.
  - fwdA=fwdB=00, stall_cnt=0. stall and bubble therefore read 0.
- Slots: ex, mem and wb each hold {v, rd, rw, mr}.
- Every edge: wb<=mem, mem<=ex. ex<=ID instruction, or invalid when bubble=1 or id_valid=0.
- A slot can only produce a hazard or a forward when v && rw && rd!=0. Register x0 is never matched.
- Hazard condition:
  - haz = id_valid && ex.v && ex.mr && ex.rw && ex.rd!=0 && ((id_use_rs1 && id_rs1==ex.rd) || (id_use_rs2 && id_rs2==ex.rd)).
- FSM:
  - RUN: if haz and !flush_in, then stall=1 and bubble=1. If LOAD_LAT>1, go to STALL with remaining=LOAD_LAT-1; otherwise stay in RUN.
  - STALL: stall=1, bubble=1, remaining decrements each edge. Return to RUN when remaining==1 at the edge.
- Flush:
  - flush_in=1 forces bubble=1 and stall=0 regardless of state.
  - FSM goes to RUN and remaining clears to 0.
  - Flush has priority over a simultaneous hazard.
- Forwarding, computed for the ID instruction and registered on the same edge it enters EX:
  - fwdA<=10 if the current ex slot matches id_rs1 (that instruction becomes EX/MEM).
  - Else fwdA<=01 if the current mem slot matches (becomes MEM/WB).
  - Else fwdA<=00.
  - fwdB is computed the same way on id_rs2.
  - A matching slot with mr=1 is never selected as 10.
  - When id_use_rsN=0 or bubble=1, fwdN<=00.
- stall_cnt increments on every edge where stall=1 and saturates at all-ones.
- The regfile is write-first, so a producer that has left wb needs no forwarding.

Decomposition:
- Package hazard_pkg:
  - slot_t struct {v, rd, rw, mr}.
  - FSM enum {RUN, STALL}.
  - FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01.
- One sub-module, fwd_select: compares one source register against two slots and returns the 2-bit select. It is instantiated twice, for A and B.

Test Plan:
- Reset mid-run: rst low for 3 cycles while the ex slot is a valid load → fwdA=fwdB=00, stall=0, stall_cnt=0 immediately, without waiting for a clock edge.
- Load-use, LOAD_LAT=1: lw x5 followed by add x6,x5,x7 → stall=1 and bubble=1 for exactly 1 cycle; add enters EX next with fwdA=01, fwdB=00; stall_cnt=1.
- Back-to-back ALU: add x3,x1,x2 then sub x4,x3,x3 → no stall; fwdA=fwdB=10. Third instruction or x4,x3,x0 → fwdA=01, fwdB=00.
- x0 guard: add x0,x1,x2 then add x9,x0,x0 → fwdA=fwdB=00, no stall. Load to x0 followed by a use of x0 → no stall.
- LOAD_LAT=3: lw x8 then use of x8 → stall high for 3 consecutive cycles; stall_cnt=3; consumer enters EX with fwdA=00 (producer already written back).
- Flush during stall (LOAD_LAT=3): flush_in=1 in the 2nd stall cycle → same cycle stall=0, bubble=1; next cycle FSM in RUN; stall_cnt=1.
